// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue unit.
// FETCH_COMPRESSED_EN enables 16-bit instruction support.
package fetch_queue_unit_pkg;

  typedef enum logic [0:0] {
    FQ_RUN       = 1'b0,
    FQ_WAIT_JALR = 1'b1
  } fq_state_e;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [1:0] C_Q1     = 2'b01;
  localparam logic [1:0] C_Q2     = 2'b10;
  localparam logic [2:0] C_F3_JAL = 3'b001;
  localparam logic [2:0] C_F3_J   = 3'b101;
  localparam logic [2:0] C_F3_JR  = 3'b100;

  localparam int FQ_INST_W  = 32;
  localparam int FQ_LEN_W   = 1;
  localparam int FQ_TAKEN_W = 1;
  localparam int JIMM_W     = 21;
  localparam int CJIMM_W    = 12;

  function automatic logic [JIMM_W-1:0] j_imm(
    input logic [FQ_INST_W-1:0] i
  );
    return {i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [CJIMM_W-1:0] cj_imm(
    input logic [15:0] c
  );
    return {c[12], c[8], c[10:9], c[6], c[7],
            c[2], c[11], c[5:3], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch queue to decoder handshake bundle.
// master drives the head entry, slave returns out_ready.
interface fetch_queue_unit_if
  import fetch_queue_unit_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic                 out_valid;
  logic                 out_ready;
  logic [FQ_INST_W-1:0] out_inst;
  logic [XLEN-1:0]      out_pc;
  logic                 out_len;
  logic                 out_pred_taken;
  logic [XLEN-1:0]      out_pred_addr;

  modport master (
    output out_valid,
    output out_inst,
    output out_pc,
    output out_len,
    output out_pred_taken,
    output out_pred_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  out_len,
    input  out_pred_taken,
    input  out_pred_addr,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue_unit_predecode.sv
// Control-flow pre-decode: flags JAL/JALR and yields the JAL offset.
// FETCH_COMPRESSED_EN adds c.j/c.jal/c.jr/c.jalr recognition.
module fetch_predecode
  import fetch_queue_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [FQ_INST_W-1:0] inst,
  input  logic                 inst_length,
  output logic                 is_jal,
  output logic                 is_jalr,
  output logic [XLEN-1:0]      jal_imm
);

  logic [JIMM_W-1:0] jimm;
  logic [XLEN-1:0]   jimm_x;

  assign jimm   = j_imm(inst);
  assign jimm_x = {{(XLEN-JIMM_W){jimm[JIMM_W-1]}}, jimm};

`ifdef FETCH_COMPRESSED_EN
  logic [CJIMM_W-1:0] cjimm;
  logic [XLEN-1:0]    cjimm_x;
  logic [1:0]         quad;
  logic [2:0]         f3;
  logic               c_j;
  logic               c_jr;

  assign cjimm   = cj_imm(inst[15:0]);
  assign cjimm_x = {{(XLEN-CJIMM_W){cjimm[CJIMM_W-1]}}, cjimm};
  assign quad    = inst[1:0];
  assign f3      = inst[15:13];

  assign c_j = !inst_length && quad == C_Q1 &&
               (f3 == C_F3_J || f3 == C_F3_JAL);

  // rs1 != 0 keeps c.ebreak and reserved encodings out
  assign c_jr = !inst_length && quad == C_Q2 &&
                f3 == C_F3_JR && inst[11:7] != 5'd0 &&
                inst[6:2] == 5'd0;

  assign is_jal  = (inst_length && inst[6:0] == OPC_JAL) || c_j;
  assign is_jalr = (inst_length && inst[6:0] == OPC_JALR) || c_jr;
  assign jal_imm = inst_length ? jimm_x : cjimm_x;
`else
  logic [5:0] unused_pd;

  assign unused_pd = {inst_length, inst[11:7]};
  assign is_jal    = inst[6:0] == OPC_JAL;
  assign is_jalr   = inst[6:0] == OPC_JALR;
  assign jal_imm   = jimm_x;
`endif

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, applies redirects, queues fetched words.
// FETCH_COMPRESSED_EN honours 16-bit instructions.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PTR_W    = $clog2(DEPTH),
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic [XLEN-1:0]      fetch_addr,
  input  logic                 inst_available,
  input  logic [FQ_INST_W-1:0] inst,
  input  logic                 inst_length,
  input  logic                 branch,
  input  logic [XLEN-1:0]      branch_addr,
  input  logic                 jalr_compute,
  input  logic [XLEN-1:0]      jalr_addr,
  input  logic                 predict_fail,
  input  logic [XLEN-1:0]      fail_addr,
  fetch_queue_unit_if.master   dq,
  output logic [PTR_W:0]       count
);

  fq_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [FQ_INST_W-1:0]  inst_q [DEPTH];
  logic [XLEN-1:0]       epc_q  [DEPTH];
  logic [FQ_LEN_W-1:0]   len_q  [DEPTH];
  logic [FQ_TAKEN_W-1:0] tkn_q  [DEPTH];
  logic [XLEN-1:0]       nxt_q  [DEPTH];

  logic            is_jal, is_jalr;
  logic [XLEN-1:0] jal_imm;
  logic            len_eff;
  logic [XLEN-1:0] inc;
  logic            empty, full, pop, can_push;
  logic            go_jalr;
  logic            push_jalr, push_jal, push_br, push_seq;
  logic            push;
  logic            e_tkn;
  logic [XLEN-1:0] e_nxt;

  fetch_predecode #(
    .XLEN(XLEN)
  ) u_pd (
    .inst       (inst),
    .inst_length(inst_length),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .jal_imm    (jal_imm)
  );

`ifdef FETCH_COMPRESSED_EN
  assign len_eff = inst_length;
`else
  assign len_eff = 1'b1;
`endif

  assign inc   = len_eff ? XLEN'(4) : XLEN'(2);
  assign empty = count_q == '0;
  assign full  = count_q == (PTR_W+1)'(DEPTH);
  assign pop   = !empty && dq.out_ready && !predict_fail;

  assign can_push = state_q == FQ_RUN && inst_available &&
                    (!full || pop) && !predict_fail;

  assign go_jalr = state_q == FQ_WAIT_JALR && jalr_compute &&
                   !predict_fail;

  // mutually exclusive so the decoder below stays unique
  assign push_jalr = can_push && is_jalr;
  assign push_jal  = can_push && is_jal;
  assign push_br   = can_push && !is_jal && !is_jalr && branch;
  assign push_seq  = can_push && !is_jal && !is_jalr && !branch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = can_push;
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    e_tkn   = 1'b0;
    e_nxt   = pc_q + inc;
    unique case (1'b1)
      predict_fail: begin
        pc_d    = fail_addr;
        state_d = FQ_RUN;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      go_jalr: begin
        pc_d    = jalr_addr;
        state_d = FQ_RUN;
      end
      push_jalr: begin
        state_d = FQ_WAIT_JALR;
        e_nxt   = '0;
      end
      push_jal: begin
        e_tkn = 1'b1;
        e_nxt = pc_q + jal_imm;
        pc_d  = e_nxt;
      end
      push_br: begin
        e_tkn = 1'b1;
        e_nxt = branch_addr;
        pc_d  = branch_addr;
      end
      push_seq: begin
        pc_d = e_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= FQ_RUN;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && push) begin
      inst_q[tail_q] <= inst;
      epc_q[tail_q]  <= pc_q;
      len_q[tail_q]  <= len_eff;
      tkn_q[tail_q]  <= e_tkn;
      nxt_q[tail_q]  <= e_nxt;
    end
  end

  // empty queue presents zeros so stale entries never leak out
  assign dq.out_valid      = !empty;
  assign dq.out_inst       = empty ? '0 : inst_q[head_q];
  assign dq.out_pc         = empty ? '0 : epc_q[head_q];
  assign dq.out_len        = empty ? 1'b0 : len_q[head_q];
  assign dq.out_pred_taken = empty ? 1'b0 : tkn_q[head_q];
  assign dq.out_pred_addr  = empty ? '0 : nxt_q[head_q];

  assign fetch_addr = pc_q;
  assign count      = count_q;

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch stage: owns the PC, drives the icache, and applies branch-predictor, JAL, JALR and mispredict redirects.
- Buffers fetched raw instructions with their PC and prediction in a DEPTH-entry circular queue, and hands them to the decoder through a valid/ready handshake.
- Decoding moves downstream; this block only pre-decodes control-flow instructions.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, queue entries (power of two, ≥2).
- PTR_W, $clog2(DEPTH), queue pointer width.
- RESET_PC, 32'h0, PC loaded at reset.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset.
- rdy_in  in  1  global enable; low freezes all state.
- fetch_addr  out  XLEN  PC to icache.
- inst_available  in  1  icache hit for fetch_addr, same cycle.
- inst  in  32  instruction from icache.
- inst_length  in  1  1 = 32-bit, 0 = 16-bit.
- branch  in  1  bp predicts taken for fetch_addr.
- branch_addr  in  XLEN  predicted target.
- jalr_compute  in  1  JALR target resolved.
- jalr_addr  in  XLEN  resolved JALR target.
- predict_fail  in  1  mispredict; redirect and flush.
- fail_addr  in  XLEN  correct PC.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decoder accepts head.
- out_inst  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_len  out  1  head inst_length.
- out_pred_taken  out  1  head predicted/unconditional taken.
- out_pred_addr  out  XLEN  head predicted next PC.
- count  out  PTR_W+1  occupancy.

Behaviour:
- Reset:
  - Single clock; reset is synchronous and active-low: on a rising clk_in edge with rst_in==0, reset takes effect.
  - Reset sets pc=RESET_PC, state=RUN, head=tail=0, count=0, out_valid=0, out_inst=0, out_pc=0, out_len=0, out_pred_taken=0, out_pred_addr=0.
- rdy_in==0 (reset inactive): no register changes.
- States:
  - RUN: fetching.
  - WAIT_JALR: stalled behind an issued JALR.
- Push condition: state==RUN && inst_available && (count<DEPTH || pop this cycle). The entry stores {inst, pc, inst_length, taken, next_pc}.
- Pop: out_valid && out_ready. out_* are combinational from the head entry; out_valid = count!=0.
- Next-PC priority, highest first:
  1. predict_fail: pc=fail_addr, state=RUN, queue flushed (count=0, head=tail=0), no push or pop.
  2. jalr_compute in WAIT_JALR: pc=jalr_addr, state=RUN. In RUN, jalr_compute is ignored.
  3. Push of a JALR: state=WAIT_JALR, pc unchanged, taken=0, next_pc=0.
  4. Push with pre-decoded JAL: pc=pc+sext(J-imm), taken=1.
  5. Push with branch==1: pc=branch_addr, taken=1.
  6. Other push: pc += inst_length ? 4 : 2, taken=0.
  7. No push: pc holds.
- Queue behaviour:
  - Full and no pop: stall; inst is dropped and refetched next cycle from the same pc.
  - Full with a simultaneous pop: push succeeds and count holds.
  - Pointers wrap modulo DEPTH.
- Arithmetic: all PC arithmetic is XLEN-bit modulo 2^XLEN. The J-imm is sign-extended from bit 20.
- Pre-decode (combinational sub-module):
  - opcode 1101111 → JAL.
  - opcode 1100111 → JALR.

Optional Feature:
- Macro: FETCH_COMPRESSED_EN.
- With the macro defined: 16-bit instructions are honoured. Pre-decode maps c.j and c.jal to JAL (CJ-imm, sign-extended from bit 11), and c.jr and c.jalr to JALR.
- Without the macro: inst_length is ignored, the increment is always 4, out_len is always 1, and no compressed pre-decode logic exists.

Decomposition:
- Shared package/macros file: state encodings (FQ_RUN, FQ_WAIT_JALR), opcode constants (OPC_JAL, OPC_JALR), compressed quadrant/funct3 constants, and the queue entry field widths.
- One sub-module, fetch_predecode:
  - Inputs: inst, inst_length.
  - Outputs: is_jal, is_jalr, jal_imm[XLEN].
  - Purely combinational.

Test Plan:
- Sequential fetch: reset with RESET_PC=0; icache always hits with ADDI; out_ready=1 → out_pc sequence is 0,4,8,…, and count never exceeds 1.
- Backpressure: out_ready=0 with DEPTH=4 → count reaches 4 and fetch_addr holds at 0x10. Raise out_ready → fetching resumes with no lost or duplicated PC.
- JAL redirect: inst JAL x1,+0x40 at 0x8 → next fetch_addr is 0x48, with out_pred_taken=1 and out_pred_addr=0x48 on that entry.
- JALR stall: JALR at 0xC → pc holds at 0xC for 5 cycles with no pushes. Pulse jalr_compute with jalr_addr=0x200 → fetch_addr is 0x200 next cycle.
- Mispredict flush: queue holds 3 entries; assert predict_fail with fail_addr=0x80 in the same cycle as branch=1 and jalr_compute=1 → count=0 and fetch_addr=0x80.
- Compressed (FETCH_COMPRESSED_EN): 16-bit ADDI at 0x0, then c.j −2 at 0x2 → pushed PCs are 0x0, 0x2; next fetch_addr is 0x0.
